// File: rtl/game_pkg.sv
// Shared game-side types and key constants used by the keyboard front end and
// the game-state FSM.
package game_pkg;

    typedef logic [7:0] keycode_t;

    localparam keycode_t KEY_NONE  = 8'd0;
    localparam keycode_t KEY_ESC   = 8'd41;
    localparam keycode_t KEY_SPACE = 8'd44;

    // Auto-repeat tracker: nothing held, held before first repeat, repeating.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_rep_state_t;

endpackage

// File: rtl/key_sync_debounce.sv
// Two-flop synchroniser plus stability counter for the raw keycode.
// stable_code_o is the current candidate; commit_o strobes for one cycle when
// the candidate has been stable long enough and differs from the held code.
module key_sync_debounce
    import game_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic     Clock,
    input  logic     Reset,
    input  keycode_t raw_code_i,
    input  keycode_t held_code_i,
    output keycode_t stable_code_o,
    output logic     commit_o
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    keycode_t         s1_q, s2_q;
    keycode_t         cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser, candidate and counter registers with synchronous reset.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge, independent of block order.
        if (Reset) begin
            s1_q   <= KEY_NONE;
            s2_q   <= KEY_NONE;
            cand_q <= KEY_NONE;
            cnt_q  <= '0;
        end else begin
            s1_q   <= raw_code_i;
            s2_q   <= s1_q;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    // Restart the count on any change of the synchronised code, else count up
    // and saturate at STABLE_CYCLES-1.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign stable_code_o = cand_q;
    assign commit_o      = (cnt_q == CNT_MAX) && (s2_q == cand_q) && (cand_q != held_code_i);

endmodule

// File: rtl/key_event_filter.sv
// Keyboard event conditioner: debounces the raw keycode, holds the accepted
// code, and turns level changes into one-cycle press/release pulses.
// Optional auto-repeat is compiled in with `define KEY_REPEAT_EN.
module key_event_filter
    import game_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Keycode_raw,
    output logic [7:0] Key_event,
    output logic       Key_valid,
    output logic [7:0] Key_held,
    output logic       Key_release
);

    keycode_t       stable_code;
    logic           commit;

    keycode_t       held_q, held_d;
    keycode_t       event_q, event_d;
    logic           valid_q, valid_d;
    logic           release_q, release_d;
    key_rep_state_t state_q, state_d;

`ifdef KEY_REPEAT_EN
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rcnt_q, rcnt_d;
`else
    // Repeat timing is not built; the parameters stay in the interface only.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    key_sync_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_sync_debounce (
        .Clock        (Clock),
        .Reset        (Reset),
        .raw_code_i   (Keycode_raw),
        .held_code_i  (held_q),
        .stable_code_o(stable_code),
        .commit_o     (commit)
    );

    // Held code, output pulses and repeat state; reset discards anything in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            held_q    <= KEY_NONE;
            event_q   <= KEY_NONE;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= IDLE;
`ifdef KEY_REPEAT_EN
            rcnt_q    <= '0;
`endif
        end else begin
            held_q    <= held_d;
            event_q   <= event_d;
            valid_q   <= valid_d;
            release_q <= release_d;
            state_q   <= state_d;
`ifdef KEY_REPEAT_EN
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    // Commit handling has priority; otherwise the repeat FSM may fire an event.
    always_comb begin
        held_d    = held_q;
        event_d   = KEY_NONE;
        valid_d   = 1'b0;
        release_d = 1'b0;
        state_d   = state_q;
`ifdef KEY_REPEAT_EN
        rcnt_d    = rcnt_q;
`endif
        if (commit) begin
            held_d = stable_code;
            if (stable_code != KEY_NONE) begin
                event_d = stable_code;
                valid_d = 1'b1;
            end
            if (held_q != KEY_NONE) begin
                release_d = 1'b1;
            end
            state_d = (stable_code != KEY_NONE) ? HELD : IDLE;
`ifdef KEY_REPEAT_EN
            rcnt_d  = '0;
`endif
        end else begin
`ifdef KEY_REPEAT_EN
            case (state_q)
                HELD: begin
                    if (rcnt_q == DELAY_LAST) begin
                        event_d = held_q;
                        valid_d = 1'b1;
                        rcnt_d  = '0;
                        state_d = REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + 32'd1;
                    end
                end
                REPEAT: begin
                    if (rcnt_q == PERIOD_LAST) begin
                        event_d = held_q;
                        valid_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 32'd1;
                    end
                end
                default: begin
                    rcnt_d = '0;
                end
            endcase
`endif
        end
    end

    assign Key_event   = event_q;
    assign Key_valid   = valid_q;
    assign Key_held    = held_q;
    assign Key_release = release_q;

endmodule

// File: tb/tb_key_event_filter.sv
// Scoreboard bench for key_event_filter with STABLE_CYCLES=4. The reference
// model accepts a code once the last STABLE_CYCLES+1 raw samples, seen through
// the two-cycle synchroniser, all agree and differ from the held code.
module tb_key_event_filter;

    localparam int unsigned SC = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] raw = 8'd0;
    logic [7:0] key_event;
    logic       key_valid;
    logic [7:0] key_held;
    logic       key_release;

    key_event_filter #(
        .STABLE_CYCLES(SC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Keycode_raw(raw),
        .Key_event  (key_event),
        .Key_valid  (key_valid),
        .Key_held   (key_held),
        .Key_release(key_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned stamp;
        logic [7:0]  ev;
        logic        rel;
        logic [7:0]  held;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  hist[$];
    logic [7:0]  m_held = 8'd0;
    int unsigned m_t    = 0;
    int unsigned m_base = 0;
    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;
    int unsigned edge_no = 0;

    // Edges since the last reset edge; edge 1 is the first with Reset low.
    always @(posedge clk) edge_no <= rst ? 0 : edge_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_no);
        end
    endtask

    // Drive one cycle of stimulus and predict the outputs after the next edge.
    task automatic step(input logic r, input logic [7:0] v);
        logic [7:0] w;
        logic [7:0] ev;
        logic       rel;
        bit         stable;
        @(negedge clk);
        rst = r;
        raw = v;
        if (r) begin
            m_t    = 0;
            m_held = 8'd0;
            m_base = 0;
            hist.delete();
            for (int k = 0; k < 8; k++) hist.push_back(8'd0);
            exp_q.delete();
        end else begin
            m_t++;
            hist.push_back(v);
            if (hist.size() > 16) void'(hist.pop_front());
            w      = hist[hist.size() - 3];
            stable = 1'b1;
            for (int k = 3; k <= 3 + int'(SC); k++)
                if (hist[hist.size() - k] != w) stable = 1'b0;
            ev  = 8'd0;
            rel = 1'b0;
            if (stable && w != m_held) begin
                ev     = w;
                rel    = (m_held != 8'd0);
                m_held = w;
                m_base = m_t;
            end else if (REP_EN && m_held != 8'd0 && m_t >= m_base + RD &&
                         ((m_t - m_base - RD) % RP) == 0) begin
                ev = m_held;
            end
            if (ev != 8'd0 || rel) exp_q.push_back('{m_t, ev, rel, m_held});
        end
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        repeat (n) step(1'b0, v);
    endtask

    // Monitor: compares every DUT pulse against the scoreboard, and the held code each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("reset_event", key_event, 0);
                check("reset_valid", key_valid, 0);
                check("reset_release", key_release, 0);
                check("reset_held", key_held, 0);
            end else begin
                check("held", key_held, m_held);
                if (key_valid || key_release || key_event != 8'd0) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_event", key_event, 0);
                        check("spurious_valid", key_valid, 0);
                        check("spurious_release", key_release, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_edge", edge_no, e.stamp);
                        check("event_code", key_event, e.ev);
                        check("event_valid", key_valid, (e.ev != 8'd0));
                        check("event_release", key_release, e.rel);
                        check("event_held", key_held, e.held);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].stamp <= edge_no) begin
                    e = exp_q.pop_front();
                    check("missed_event", key_event, e.ev);
                    check("missed_release", key_release, e.rel);
                end
            end
        end
    end

    // Directed scenarios followed by random key activity.
    initial begin
        logic [7:0] v;
        repeat (3) step(1'b1, 8'd0);
        hold(8'd44, 20);                 // press Space: event at edge 7
        hold(8'd41, 20);                 // direct change: release + Esc press together
        hold(8'd0, 20);                  // release only
        hold(8'd41, 4);                  // glitch shorter than STABLE_CYCLES+1 samples
        hold(8'd0, 20);
        hold(8'd44, 5);                  // exactly STABLE_CYCLES+1 samples: commits
        hold(8'd0, 20);
        hold(8'd41, 1000);               // long hold
        hold(8'd0, 20);
        hold(8'd44, 20);                 // reset while held, then fresh press
        step(1'b1, 8'd44);
        step(1'b1, 8'd44);
        hold(8'd44, 20);
        hold(8'd0, 20);
        for (int r = 0; r < 300; r++) begin
            case ($urandom_range(0, 3))
                0:       v = 8'd0;
                1:       v = 8'd41;
                2:       v = 8'd44;
                default: v = 8'($urandom_range(1, 255));
            endcase
            hold(v, int'($urandom_range(1, 12)));
        end
        hold(8'd0, 30);
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_filter.md
# key_event_filter

Upstream conditioner between the USB/NIOS keyboard keycode register and the game-state FSM. It synchronises the raw 8-bit keycode and rejects glitches with a stability counter. It converts the held level into one-cycle press events, so a held Esc or Space triggers exactly one state transition. It also exports the debounced held code, and can optionally generate auto-repeat events for menu navigation.

## Interface
- STABLE_CYCLES, 16: cycles the synchronised keycode must stay unchanged before it is accepted; legal range ≥1.
- REPEAT_DELAY, 25_000_000: cycles from press event to first repeat event; used only with repeat compiled in.
- REPEAT_PERIOD, 5_000_000: cycles between subsequent repeat events; used only with repeat compiled in.
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Keycode_raw  in  8  asynchronous raw keycode; 0 = no key.
- Key_event  out  8  one-cycle keycode of an accepted press or repeat; 0 otherwise; feeds the game-state FSM Keycode input.
- Key_valid  out  1  high exactly when Key_event ≠ 0.
- Key_held  out  8  debounced currently-held keycode; 0 = none.
- Key_release  out  1  one-cycle pulse when Key_held leaves a nonzero value.

## Operation
- **Sync:** two flops, s1 ← Keycode_raw, s2 ← s1.
- **Stability:** registers cand (8 bit) and cnt (width $clog2(STABLE_CYCLES+1)).
  - s2 ≠ cand: cand ← s2, cnt ← 0.
  - s2 = cand and cnt < STABLE_CYCLES-1: cnt increments.
  - s2 = cand and cnt = STABLE_CYCLES-1: cnt saturates.
- **Commit:** occurs on an edge where cnt = STABLE_CYCLES-1, s2 = cand and cand ≠ Key_held.
  - Key_held ← cand.
  - If cand ≠ 0: Key_event ← cand, Key_valid ← 1.
  - If old Key_held ≠ 0: Key_release ← 1.
  - A direct change from code A to code B yields a release and a B press on the same cycle.
  - A change to 0 yields a release only, with no event.
- **Glitch rejection:** a raw value held for fewer than STABLE_CYCLES+1 consecutive samples never commits.
- **Repeat FSM:** enum IDLE, HELD, REPEAT with a repeat counter rcnt (32 bit).
  - IDLE → HELD on a nonzero commit.
  - Any commit returns the FSM to HELD (nonzero code) or IDLE (zero code), with rcnt ← 0.
  - Without repeat compiled in, HELD is terminal until the next commit.
- **Outputs:** Key_event, Key_valid and Key_release are registered pulses, cleared every cycle unless set.
- **Reset values:** all outputs 0; s1, s2, cand, cnt, rcnt 0; FSM in IDLE.
- **Reset mid-operation:** any in-flight event or counter is discarded. A key still held after Reset deasserts produces a fresh press event after the full latency, so the main menu can see Space.

## Timing
- Edge 1 is the first edge sampling a new stable raw value.
- Key_held, Key_event, Key_valid and Key_release all update at edge STABLE_CYCLES+3; total latency is STABLE_CYCLES+3 cycles.
- Event pulses are exactly one cycle wide, with no back-to-back press events for a single physical press.
- **Repeat schedule** (compiled in, E = commit edge): events at E+REPEAT_DELAY, then E+REPEAT_DELAY+k·REPEAT_PERIOD for k ≥ 1, while Key_held is unchanged.
- **Simultaneous commit and repeat expiry:** the commit wins; the new code is emitted and rcnt restarts.
- Key_event is registered, with no combinational path from Keycode_raw.

## Configuration
- **KEY_REPEAT_EN defined:** the REPEAT state and rcnt logic are present, and REPEAT_DELAY and REPEAT_PERIOD apply.
- **KEY_REPEAT_EN undefined:** rcnt and the REPEAT state are removed; exactly one Key_event per accepted press. REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Structure
- **Shared package game_pkg:**
  - typedef keycode_t (logic [7:0]);
  - constants KEY_NONE = 8'd0, KEY_ESC = 8'd41, KEY_SPACE = 8'd44;
  - enum key_rep_state_t {IDLE, HELD, REPEAT}.
- **Sub-module key_sync_debounce:** contains s1, s2, cand and cnt. Outputs stable_code plus a one-cycle commit strobe; the top level holds Key_held, the pulses and the repeat FSM.

## Test plan
All scenarios use STABLE_CYCLES=4.
- **Press:** Reset, raw 0 → 44 held → Key_event = 44 and Key_valid = 1 for exactly one cycle at edge 7; Key_held = 44 thereafter.
- **Glitch:** raw 41 for 4 cycles then back to 0 → Key_event, Key_held and Key_release stay 0.
- **Hold without repeat:** raw 41 held for 1000 cycles, KEY_REPEAT_EN undefined → exactly one Key_event = 41.
- **Release and change:** raw 44 → 41 after Key_held = 44 → at one edge Key_release = 1, Key_event = 41, Key_held = 41. Then raw 41 → 0 → Key_release pulse with no event.
- **Repeat:** KEY_REPEAT_EN defined, REPEAT_DELAY=10, REPEAT_PERIOD=3, raw 44 held → events at E, E+10, E+13, E+16.
- **Reset mid-hold:** Reset pulsed while raw 44 is held with Key_held = 44 → outputs 0 during reset, then a new Key_event = 44 at edge 7 after Reset deasserts.
